// File: rtl/timer_dev_pkg.sv
// rtl/timer_dev_pkg.sv - shared register map, ctrl bit layout, mode codes and FSM encoding for timer_dev
package timer_dev_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM       = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_AUTO    = 2'd1;

    // Bridge-side base addresses, shared with software test generators.
    localparam logic [31:0] DEV0_BASE = 32'h0000_7F00;
    localparam logic [31:0] DEV1_BASE = 32'h0000_7F10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

endpackage

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer with one-shot and auto-reload modes
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [CNT_W-1:0] din,
    output logic [CNT_W-1:0] dout,
    output logic             irq
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    timer_state_e     state_q, state_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             irq_flag_q, irq_flag_d;

    logic en;
    logic auto_mode;

    assign en        = ctrl_q[CTRL_EN];
    assign auto_mode = (ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_AUTO);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (count_q > ONE) begin
                    count_d = count_q - ONE;
                end else begin
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = ST_INT;
                end
            end
            ST_INT: begin
                if (auto_mode) begin
                    irq_flag_d = 1'b0;
                    state_d    = en ? ST_LOAD : ST_IDLE;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus writes come last so they override FSM updates to ctrl and irq_flag.
        if (we && addr == ADDR_CTRL) begin
            ctrl_d     = din[3:0];
            irq_flag_d = 1'b0;
        end
        if (we && addr == ADDR_PRESET) begin
            preset_d   = din;
            irq_flag_d = 1'b0;
        end
    end

    always_comb begin
        case (addr)
            ADDR_CTRL:   dout = {{(CNT_W-4){1'b0}}, ctrl_q};
            ADDR_PRESET: dout = preset_q;
            ADDR_COUNT:  dout = count_q;
            default:     dout = '0;
        endcase
    end

    assign irq = irq_flag_q & ctrl_q[CTRL_IM];

endmodule
